// File: rtl/sub16_serial.sv
// Digit-serial unsigned subtractor: out = in1 - in2, ovfl = borrow out.
// One DIGIT_W-bit subtract cell per cycle, LSB digit first; done pulses on completion.
module sub16_serial #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             ovfl,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NDIG  = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned LAST  = NDIG - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               ovfl_q, ovfl_d;
  logic [DIGIT_W:0]   diff;
  logic [WIDTH-1:0]   a_shift;

  assign diff = {1'b0, a_q[DIGIT_W-1:0]} - {1'b0, b_q[DIGIT_W-1:0]}
              - (DIGIT_W+1)'(borrow_q);

  // The minuend register doubles as the result register: each consumed
  // digit of A is replaced from the MSB side by the matching result digit.
  if (DIGIT_W == WIDTH) begin : g_single
    assign a_shift = diff[DIGIT_W-1:0];
  end else begin : g_multi
    assign a_shift = {diff[DIGIT_W-1:0], a_q[WIDTH-1:DIGIT_W]};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    out_d    = out_q;
    ovfl_d   = ovfl_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = in1;
          b_d      = in2;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_d      = a_shift;
        b_d      = b_q >> DIGIT_W;
        borrow_d = diff[DIGIT_W];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAST)) begin
          out_d   = a_shift;
          ovfl_d  = diff[DIGIT_W];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      out_q    <= '0;
      ovfl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      out_q    <= out_d;
      ovfl_q   <= ovfl_d;
    end
  end

  assign out  = out_q;
  assign ovfl = ovfl_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_sub16_serial.sv
// Scoreboard bench for sub16_serial: default 4-bit-digit build and a DIGIT_W=16 build.
module tb_sub16_serial;

  logic        clk = 1'b0;
  logic        rst, start, start2;
  logic [15:0] in1, in2, out, out2;
  logic        ovfl, busy, done, ovfl2, busy2, done2;

  always #5 clk = ~clk;

  sub16_serial #(.WIDTH(16), .DIGIT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .out(out), .ovfl(ovfl), .busy(busy), .done(done)
  );

  sub16_serial #(.WIDTH(16), .DIGIT_W(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in1(in1), .in2(in2),
    .out(out2), .ovfl(ovfl2), .busy(busy2), .done(done2)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eo;
    logic        ev;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   tests = 0;
  int   fails = 0;
  int   ndone1 = 0;
  int   ndone2 = 0;
  exp_t e1, e2;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Compare against the hand value and against the inverse operation (add).
  function automatic void score(string tag, exp_t e, logic [15:0] o, logic v, logic b);
    logic [16:0] sum;
    chk({tag, "_out"}, 32'(o), 32'(e.eo));
    chk({tag, "_ovfl"}, 32'(v), 32'(e.ev));
    sum = {1'b0, o} + {1'b0, e.b};
    chk({tag, "_golden_sum"}, 32'(sum[15:0]), 32'(e.a));
    chk({tag, "_golden_carry"}, 32'(sum[16]), 32'(v));
    chk({tag, "_busy_in_done"}, 32'(b), 32'd1);
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      ndone1++;
      chk("dut_done_has_entry", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        score("dut", e1, out, ovfl, busy);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done2) begin
      ndone2++;
      chk("dut2_done_has_entry", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        score("dut2", e2, out2, ovfl2, busy2);
      end
    end
  end

  task automatic do_op(input bit w, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eo, input logic ev, input int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    in1 = a;
    in2 = b;
    if (w) start2 = 1'b1; else start = 1'b1;
    e = '{a, b, eo, ev};
    if (w) q2.push_back(e); else q1.push_back(e);
    @(posedge clk);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
    in1    = ~a;
    in2    = ~b;
    chk("busy_after_accept", 32'(w ? busy2 : busy), 32'd1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(w ? done2 : done) && n < 20);
    chk("latency", 32'(n), 32'(lat));
    @(posedge clk);
    #1;
    chk("idle_after_done", 32'(w ? busy2 : busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; in1 = '0; in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_ovfl", 32'(ovfl), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    rst = 1'b0;

    do_op(0, 16'h0002, 16'h0001, 16'h0001, 1'b0, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_out", 32'(out), 32'h0001);
    do_op(0, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 4);
    do_op(0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 4);
    do_op(0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 4);
    do_op(0, 16'h0F0F, 16'hF0F0, 16'h1E1F, 1'b1, 4);

    // start held high: accepts land on cycles 0, 6 and 12 only
    d0 = ndone1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      start = 1'b1;
      case (k)
        0:  begin in1 = 16'h5000; in2 = 16'h1000; q1.push_back('{16'h5000, 16'h1000, 16'h4000, 1'b0}); end
        6:  begin in1 = 16'h0100; in2 = 16'h0200; q1.push_back('{16'h0100, 16'h0200, 16'hFF00, 1'b1}); end
        12: begin in1 = 16'hABCD; in2 = 16'h0BCD; q1.push_back('{16'hABCD, 16'h0BCD, 16'hA000, 1'b0}); end
        default: begin in1 = 16'hDEAD ^ 16'(k); in2 = 16'hBEEF + 16'(k); end
      endcase
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("held_start_done_count", 32'(ndone1 - d0), 32'd3);

    // reset two edges after accept aborts the operation
    @(negedge clk);
    in1 = 16'h1234; in2 = 16'h0034; start = 1'b1;
    q1.push_back('{16'h1234, 16'h0034, 16'h1200, 1'b0});
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    q1.delete();
    @(posedge clk);
    #1;
    chk("abort_out", 32'(out), 32'd0);
    chk("abort_ovfl", 32'(ovfl), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    d0 = ndone1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(ndone1 - d0), 32'd0);
    do_op(0, 16'h1234, 16'h0034, 16'h1200, 1'b0, 4);

    do_op(1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1);
    chk("dut2_done_count", 32'(ndone2), 32'd1);

    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
